// File: rtl/gpio_key_debouncer.sv
// Per-key debouncer for the GPIO header keys: synchronises, filters and normalises raw contacts,
// and emits one-cycle press/release strobes alongside the debounced level.
module gpio_key_debouncer #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned STABLE_TICKS = 5,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] raw_keys,
   input  logic             enable,
   output logic [WIDTH-1:0] keys_out,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] release_pulse,
   output logic             any_change,
   output logic             tick
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
   // Synchroniser resets to the released level so reset never looks like a press.
   localparam logic [WIDTH-1:0] IDLE_LEVEL = {WIDTH{ACTIVE_LOW}};

   logic [WIDTH-1:0] sync1_q, sync2_q, sample;
   logic [PW-1:0]    pre_q;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic [WIDTH-1:0] keys_d, press_d, release_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= IDLE_LEVEL;
         sync2_q <= IDLE_LEVEL;
      end else begin
         sync1_q <= raw_keys;
         sync2_q <= sync1_q;
      end
   end

   assign sample = sync2_q ^ IDLE_LEVEL;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q <= '0;
      end else if (!enable || pre_q == PRE_LAST) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + 1'b1;
      end
   end

   assign tick = enable && (pre_q == PRE_LAST);

   // Any sample equal to the accepted level restarts that key's filter, even between ticks.
   always_comb begin
      keys_d    = keys_out;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (!enable) begin
            cnt_d[i] = '0;
         end else if (sample[i] == keys_out[i]) begin
            cnt_d[i] = '0;
         end else if (tick) begin
            if (cnt_q[i] == CNT_LAST) begin
               keys_d[i]    = sample[i];
               cnt_d[i]     = '0;
               press_d[i]   = sample[i];
               release_d[i] = ~sample[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         keys_out      <= '0;
         press_pulse   <= '0;
         release_pulse <= '0;
         any_change    <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         keys_out      <= keys_d;
         press_pulse   <= press_d;
         release_pulse <= release_d;
         any_change    <= |(press_d | release_d);
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: doc/gpio_key_debouncer.md
# gpio_key_debouncer

Per-key debouncer and edge-pulse generator for the 32 piano-key inputs on the GPIO expansion header. It sits directly upstream of the Nios II GPIO PIO input port. Raw mechanical contacts are synchronised, filtered, and polarity-normalised here, so the PIO's any-edge capture and IRQ see exactly one transition per physical press or release. It also provides per-key one-cycle press/release strobes for the hardware tone logic.

## Interface
- WIDTH, 32: number of key inputs.
- TICK_DIV, 50000: clk cycles per sample tick (1 ms at 50 MHz); legal range ≥1; 1 means a tick every cycle.
- STABLE_TICKS, 5: consecutive ticks a new level must persist before it is accepted; legal range ≥1.
- ACTIVE_LOW, 1: 1 means a key is pulled up and pressed = 0; outputs always use 1 = pressed.

- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- raw_keys  in  WIDTH  asynchronous key contacts from the header.
- enable  in  1  filter enable; 0 freezes the debounced state.
- keys_out  out  WIDTH  debounced, normalised key state (1 = pressed); feeds the PIO input.
- press_pulse  out  WIDTH  one-cycle strobe when keys_out[i] goes 0→1.
- release_pulse  out  WIDTH  one-cycle strobe when keys_out[i] goes 1→0.
- any_change  out  1  OR of press_pulse and release_pulse.
- tick  out  1  prescaler tick, exposed for debug and bench alignment.

## Operation
- Synchroniser: 2-FF per bit, free-running regardless of enable.
  - Reset value: all 1s when ACTIVE_LOW=1, all 0s otherwise, so reset never produces a phantom press.
  - Normalised sample s = sync2 XOR {WIDTH{ACTIVE_LOW}}.
- Prescaler: counter runs 0..TICK_DIV-1 and wraps.
  - tick = 1 when count == TICK_DIV-1 and enable = 1.
  - enable = 0 holds count at 0.
- Per-key counter cnt[i], width clog2(STABLE_TICKS+1), evaluated every clock in priority order:
  1. enable = 0 → cnt := 0; keys_out holds.
  2. s[i] == keys_out[i] → cnt := 0 (any bounce back restarts the filter, even between ticks).
  3. tick and cnt == STABLE_TICKS-1 → keys_out[i] := s[i]; cnt := 0; assert press_pulse[i] or release_pulse[i] for that transition.
  4. tick → cnt := cnt + 1.
  5. Otherwise hold.
- Saturation: cnt never exceeds STABLE_TICKS-1, so there is no wrap-around.
- Keys are fully independent. Any number of bits may flip on the same tick, and their pulses are asserted in the same cycle.
- Pulses are registered alongside keys_out, high exactly one cycle, and 0 otherwise.

## Timing
- Reset values (async):
  - keys_out, press_pulse, release_pulse, any_change, tick = 0.
  - All cnt and the prescaler = 0.
  - Synchroniser at its inactive level (see Operation).
- keys_out and its pulse change on the same clock edge, namely the edge at which the qualifying tick is sampled high.
- Latency from a raw level change (stable from then on) to the keys_out change: between 2+(STABLE_TICKS-1)·TICK_DIV+1 and 2+STABLE_TICKS·TICK_DIV clk edges.
- Any glitch shorter than STABLE_TICKS-1 full tick periods, or any return to the old level before the qualifying tick, produces no output change.
- Reset asserted mid-count clears everything immediately. After release, the first acceptance needs the full latency again.
- enable deasserted mid-count discards progress. After enable returns, the prescaler restarts from 0.
- The PIO stage adds 1 cycle before the level is readable and 2 cycles before edge capture. This block adds no further combinational path to it.

## Test plan
All scenarios use TICK_DIV=4, STABLE_TICKS=3, ACTIVE_LOW=1.

- Reset: hold raw_keys=0xFFFFFFFF, release reset → keys_out=0 and no pulses for 100 cycles.
- Clean press: raw_keys[5] 1→0 and held → keys_out[5]=1 within 11–14 cycles; press_pulse[5] and any_change each high exactly 1 cycle; other bits 0.
- Bounce: toggle raw_keys[3] every 5 cycles for 60 cycles, then leave it at 1 → keys_out[3] stays 0 with zero pulses. Then hold it 0 → press after 11–14 cycles.
- Simultaneous: raw_keys[0] and [31] pressed in the same cycle → both keys_out bits rise on the same edge; press_pulse=0x80000001 for 1 cycle. Releasing both → release_pulse=0x80000001.
- Enable: press bit 7, drop enable after 2 ticks for 20 cycles, restore it → keys_out[7] rises 3 full ticks after restore, not earlier.
- Mid-count reset: press bit 9, assert reset_n=0 after 1 tick → all outputs 0 immediately. After release with the key still held → press accepted after the full 11–14 cycle latency.
